vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA timing generator for any raster mode. Replaces the fixed 640x480 controller. Generates, all from one registered stage and mutually aligned:
- hsync and vsync with configurable porches and polarity
- active_video
- visible-pixel coordinates
- line_start and frame_start strobes
Sits between the pixel clock source and the pixel/colour pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync asserted level (0 = active-low)
V_SYNC_POL, 0, vsync asserted level
CNT_W, 10, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk_25MHz  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
pix_ce  in  1  pixel clock-enable (present only with VGA_TIMING_PIXEL_CE_EN)
hsync  out  1  horizontal sync, level per H_SYNC_POL
vsync  out  1  vertical sync, level per V_SYNC_POL
active_video  out  1  high while in the visible region
x  out  CNT_W  visible column 0..H_ACTIVE-1; 0 during blanking
y  out  CNT_W  visible row 0..V_ACTIVE-1; 0 during vertical blanking
line_start  out  1  one-cycle strobe at h=0 of every line (all V_TOTAL lines)
frame_start  out  1  one-cycle strobe at h=0, v=0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Counter origin is the first visible pixel. h_cnt runs 0..H_TOTAL-1, then wraps to 0.
- v_cnt increments only when h_cnt wraps. v_cnt wraps to 0 after V_TOTAL-1.
- Decodes, computed from the current (h_cnt, v_cnt):
  - active: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
  - hsync asserted: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (default 656..751)
  - vsync asserted: V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (default lines 490..491); applies to the whole line
- Latency: every output is registered from the same counter value. Exactly 1 cycle of latency, and all outputs are cycle-aligned with each other (no mixed combinational/registered outputs).
- x equals h_cnt when h_cnt < H_ACTIVE, else 0. y equals v_cnt when v_cnt < V_ACTIVE, else 0.
- Reset (at any time, including mid-frame): at the next edge, both counters go to 0 and outputs take these values:
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL
  - active_video = 0, x = 0, y = 0
  - line_start = 0, frame_start = 0
- First edge after reset deasserts: outputs present state (0,0), i.e. active_video=1, line_start=1, frame_start=1, x=0, y=0. The counters advance to (1,0) on that same edge.
- Frame period: H_TOTAL*V_TOTAL cycles (default 420000). frame_start fires exactly once per frame.
- Elaboration check: $error if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CNT_W-1, or if any porch or sync parameter is 0.

Optional Feature:
VGA_TIMING_PIXEL_CE_EN
- Defined:
  - pix_ce port exists.
  - Counters and all output registers update only on edges where pix_ce=1; with pix_ce=0, everything holds.
  - Strobes last one enabled period.
  - Reset overrides pix_ce.
- Undefined: no pix_ce port; behaviour is identical to pix_ce tied to 1.

Decomposition:
- Package vga_timing_pkg holds:
  - mode constant sets: 640x480@60 defaults and 800x600@60 (40 MHz: 800/40/128/88, 600/1/4/23, positive polarity)
  - a function computing total = active+fp+sync+bp
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical):
  - generic modulo-N counter with enable input and wrap output
  - also decodes active and sync regions from ACTIVE/FP/SYNC/BP parameters

Test Plan:
- Reset held 5 cycles, then released -> during reset hsync=vsync=1, active_video=0, x=y=0. First cycle after release: frame_start=1, line_start=1, active_video=1, x=0, y=0.
- Default mode, one line -> active_video high for 640 cycles, x counts 0..639; hsync low for 96 cycles starting 656 cycles after line_start; line_start period 800.
- Full frame -> vsync low for 1600 cycles starting 392000 cycles after frame_start; 307200 active cycles; last active pixel x=639, y=479; next frame_start 420000 cycles later.
- 800x600 constants with H_SYNC_POL=V_SYNC_POL=1 -> hsync high for 128 cycles at h=840; frame period 1056*628 = 663168 cycles.
- Reset asserted at h=300, v=200 for 1 cycle -> next edge shows reset values; the frame then restarts from (0,0) with frame_start on the following edge.
- VGA_TIMING_PIXEL_CE_EN defined, pix_ce toggling 1,0 -> all outputs hold on pix_ce=0 cycles; line length is 1600 clk edges; frame_start width is 2 cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the parametrised VGA timing generator:
// standard mode constant sets and the raster-total helper.
package vga_timing_pkg;

    // One complete raster mode: visible size, porches, sync widths, polarity.
    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        bit          h_sync_pol;
        bit          v_sync_pol;
    } vga_mode_t;

    // 640x480@60, 25.175 MHz nominal (run at 25 MHz), negative syncs.
    localparam vga_mode_t VGA_MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
        h_sync_pol: 1'b0, v_sync_pol: 1'b0
    };

    // 800x600@60, 40 MHz pixel clock, positive syncs.
    localparam vga_mode_t VGA_MODE_800X600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        h_sync_pol: 1'b1, v_sync_pol: 1'b1
    };

    // Length of one axis in pixels (horizontal) or lines (vertical).
    function automatic int vga_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the timing generator to the pixel pipeline.
// CNT_W must match the CNT_W of the generator that drives it.
interface vga_timing_gen_if #(
    parameter int CNT_W = 10
);
    logic             hsync;
    logic             vsync;
    logic             active_video;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;

    modport master (
        output hsync, vsync, active_video, x, y, line_start, frame_start
    );

    modport slave (
        input  hsync, vsync, active_video, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: modulo-TOTAL counter with enable and wrap strobe, plus
// combinational decode of the visible and sync regions of the current count.
// Instantiated once per line (horizontal) and once per frame (vertical).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CNT_W  = 10
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             active,
    output logic             in_sync
);

    localparam int               TOTAL    = vga_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

    // Advance on enable, returning to the first visible position after LAST.
    always_ff @(posedge clk_25MHz) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values.
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign wrap    = en && (cnt == LAST);
    assign active  = (cnt < ACT_END);
    assign in_sync = (cnt >= SYNC_BEG) && (cnt < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. hsync, vsync, active_video,
// x/y and the line/frame strobes all come from one register stage fed by the
// same counter value, so they stay cycle-aligned with one cycle of latency.
// Optional build macro VGA_TIMING_PIXEL_CE_EN adds a pix_ce port; when it is
// absent the generator advances on every clock edge.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_MODE_640X480_60.h_active,
    parameter int H_FP       = VGA_MODE_640X480_60.h_fp,
    parameter int H_SYNC     = VGA_MODE_640X480_60.h_sync,
    parameter int H_BP       = VGA_MODE_640X480_60.h_bp,
    parameter int V_ACTIVE   = VGA_MODE_640X480_60.v_active,
    parameter int V_FP       = VGA_MODE_640X480_60.v_fp,
    parameter int V_SYNC     = VGA_MODE_640X480_60.v_sync,
    parameter int V_BP       = VGA_MODE_640X480_60.v_bp,
    parameter bit H_SYNC_POL = VGA_MODE_640X480_60.h_sync_pol,
    parameter bit V_SYNC_POL = VGA_MODE_640X480_60.v_sync_pol,
    parameter int CNT_W      = 10
) (
    input  logic             clk_25MHz,
    input  logic             reset,
`ifdef VGA_TIMING_PIXEL_CE_EN
    input  logic             pix_ce,
`endif
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Reject modes the counters cannot represent or that lack a blanking phase.
    if (longint'(H_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
    end
    if (longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end

    logic ce;
`ifdef VGA_TIMING_PIXEL_CE_EN
    assign ce = pix_ce;
`else
    assign ce = 1'b1;
`endif

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_active;
    logic             v_active;
    logic             h_in_sync;
    logic             v_in_sync;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_cnt (
        .clk_25MHz (clk_25MHz),
        .reset     (reset),
        .en        (ce),
        .cnt       (h_cnt),
        .wrap      (h_wrap),
        .active    (h_active),
        .in_sync   (h_in_sync)
    );

    // The vertical axis steps once per completed line.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_cnt (
        .clk_25MHz (clk_25MHz),
        .reset     (reset),
        .en        (h_wrap),
        .cnt       (v_cnt),
        .wrap      (v_wrap),
        .active    (v_active),
        .in_sync   (v_in_sync)
    );

    // A frame can only end on the last pixel of the last line.
    always_ff @(posedge clk_25MHz) begin
        if (!reset && v_wrap) begin
            assert (h_wrap && h_cnt == CNT_W'(H_TOTAL - 1));
        end
    end

    // Register every output from the same (h_cnt, v_cnt) snapshot.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            vga.hsync        <= ~H_SYNC_POL;
            vga.vsync        <= ~V_SYNC_POL;
            vga.active_video <= 1'b0;
            vga.x            <= '0;
            vga.y            <= '0;
            vga.line_start   <= 1'b0;
            vga.frame_start  <= 1'b0;
        end else if (ce) begin
            vga.hsync        <= h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
            vga.vsync        <= v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
            vga.active_video <= h_active && v_active;
            vga.x            <= h_active ? h_cnt : '0;
            vga.y            <= v_active ? v_cnt : '0;
            vga.line_start   <= (h_cnt == '0);
            vga.frame_start  <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Two small raster modes keep whole
// frames short: mode A (8/2/3/3 x 6/1/2/2, negative syncs, 16x11 raster) and
// mode B (4/1/2/1 x 3/1/1/1, positive syncs, 8x6 raster). The stimulus process
// pushes the expected registered outputs of both DUTs for every edge; the
// monitor pops one entry per edge and compares on the falling clock edge.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 3;
    localparam int A_VA = 6, A_VF = 1, A_VS = 2, A_VB = 2;
    localparam int A_HT = 16, A_VT = 11;
    localparam int B_HA = 4, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VA = 3, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_HT = 8, B_VT = 6;
`ifdef VGA_TIMING_PIXEL_CE_EN
    localparam int CEF = 2;
`else
    localparam int CEF = 1;
`endif

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       av;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
        bit   rst;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
`ifdef VGA_TIMING_PIXEL_CE_EN
    logic pix_ce;
`endif

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(10)) vga_a ();
    vga_timing_gen_if #(.CNT_W(10)) vga_b ();

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CNT_W(10)
    ) dut_a (
        .clk_25MHz (clk),
        .reset     (reset),
`ifdef VGA_TIMING_PIXEL_CE_EN
        .pix_ce    (pix_ce),
`endif
        .vga       (vga_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(10)
    ) dut_b (
        .clk_25MHz (clk),
        .reset     (reset),
`ifdef VGA_TIMING_PIXEL_CE_EN
        .pix_ce    (pix_ce),
`endif
        .vga       (vga_b)
    );

    int   checks  = 0;
    int   errors  = 0;
    int   mon_cyc = 0;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", name, mon_cyc, act, exp);
        end
    endtask

    task automatic check_obs(input string p, input obs_t got, input obs_t exp);
        check({p, ".hsync"},        32'(got.hs), 32'(exp.hs));
        check({p, ".vsync"},        32'(got.vs), 32'(exp.vs));
        check({p, ".active_video"}, 32'(got.av), 32'(exp.av));
        check({p, ".x"},            32'(got.x),  32'(exp.x));
        check({p, ".y"},            32'(got.y),  32'(exp.y));
        check({p, ".line_start"},   32'(got.ls), 32'(exp.ls));
        check({p, ".frame_start"},  32'(got.fs), 32'(exp.fs));
    endtask

    // Reference: outputs that position (h, v) must produce one edge later.
    function automatic obs_t model_out(input int h, input int v,
                                       input int ha, input int hf, input int hs,
                                       input int va, input int vf, input int vs,
                                       input bit hpol, input bit vpol);
        obs_t o;
        o.av = (h < ha) && (v < va);
        o.hs = (h >= ha + hf && h < ha + hf + hs) ? hpol : !hpol;
        o.vs = (v >= va + vf && v < va + vf + vs) ? vpol : !vpol;
        o.x  = (h < ha) ? 10'(h) : 10'd0;
        o.y  = (v < va) ? 10'(v) : 10'd0;
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic obs_t reset_out(input bit hpol, input bit vpol);
        obs_t o;
        o    = '0;
        o.hs = !hpol;
        o.vs = !vpol;
        return o;
    endfunction

    int   ah = 0, av = 0, bh = 0, bv = 0;
    obs_t a_out, b_out;

    // Apply inputs for the coming edge, push its expected result, step past it.
    task automatic drive(input bit r, input bit c);
        bit   ce_eff;
        exp_t e;
        reset = r;
`ifdef VGA_TIMING_PIXEL_CE_EN
        pix_ce = c;
        ce_eff = c;
`else
        ce_eff = 1'b1;
`endif
        if (r) begin
            ah = 0; av = 0; bh = 0; bv = 0;
            a_out = reset_out(1'b0, 1'b0);
            b_out = reset_out(1'b1, 1'b1);
        end else if (ce_eff) begin
            a_out = model_out(ah, av, A_HA, A_HF, A_HS, A_VA, A_VF, A_VS, 1'b0, 1'b0);
            b_out = model_out(bh, bv, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, 1'b1, 1'b1);
            ah++;
            if (ah == A_HT) begin ah = 0; av = (av == A_VT - 1) ? 0 : av + 1; end
            bh++;
            if (bh == B_HT) begin bh = 0; bv = (bv == B_VT - 1) ? 0 : bv + 1; end
        end
        e.a   = a_out;
        e.b   = b_out;
        e.rst = r;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor state: per-frame measurements of mode A against hand counts.
    exp_t e_m;
    obs_t ga, gb;
    bit   prev_rst = 1'b0;
    bit   prev_fs  = 1'b0;
    bit   armed    = 1'b0;
    int   since = 0, act_cnt = 0, hs_low = 0, vs_low = 0, periods_seen = 0;

    // Compare each edge's outputs against the scoreboard entry for that edge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e_m = q.pop_front();
            mon_cyc++;
            ga = {vga_a.hsync, vga_a.vsync, vga_a.active_video, vga_a.x, vga_a.y,
                  vga_a.line_start, vga_a.frame_start};
            gb = {vga_b.hsync, vga_b.vsync, vga_b.active_video, vga_b.x, vga_b.y,
                  vga_b.line_start, vga_b.frame_start};
            check_obs("a", ga, e_m.a);
            check_obs("b", gb, e_m.b);
            if (e_m.rst) begin
                check("rst_a.hsync_high", 32'(ga.hs), 32'd1);
                check("rst_a.vsync_high", 32'(ga.vs), 32'd1);
                check("rst_b.hsync_low",  32'(gb.hs), 32'd0);
                check("rst_a.active_low", 32'(ga.av), 32'd0);
                check("rst_a.xy_zero",    32'({ga.x, ga.y}), 32'd0);
                armed   = 1'b0;
                prev_fs = 1'b0;
                prev_rst = 1'b1;
            end else begin
                if (prev_rst) begin
                    check("release.frame_start", 32'(ga.fs), 32'd1);
                    check("release.line_start",  32'(ga.ls), 32'd1);
                    check("release.active",      32'(ga.av), 32'd1);
                    check("release.xy_zero",     32'({ga.x, ga.y}), 32'd0);
                end
                prev_rst = 1'b0;
                if (ga.fs && !prev_fs) begin
                    if (armed) begin
                        check("frame_period",     32'(since),   32'(176 * CEF));
                        check("active_per_frame", 32'(act_cnt), 32'(48 * CEF));
                        check("hsync_low_frame",  32'(hs_low),  32'(33 * CEF));
                        check("vsync_low_frame",  32'(vs_low),  32'(32 * CEF));
                        periods_seen++;
                    end
                    armed   = 1'b1;
                    since   = 0;
                    act_cnt = 0;
                    hs_low  = 0;
                    vs_low  = 0;
                end
                prev_fs = ga.fs;
                since++;
                act_cnt += int'(ga.av);
                hs_low  += int'(!ga.hs);
                vs_low  += int'(!ga.vs);
            end
        end
    end

    bit ce_t;
    int n;

    initial begin
        reset = 1'b1;
`ifdef VGA_TIMING_PIXEL_CE_EN
        pix_ce = 1'b1;
`endif
        repeat (5) drive(1'b1, 1'b1);

        // Two full frames plus a margin, pix_ce toggling 1,0 when present.
        ce_t = 1'b1;
        for (int i = 0; i < 2 * 176 * CEF + 20; i++) begin
            drive(1'b0, ce_t);
            ce_t = ~ce_t;
        end

        // Single-cycle reset with mode A counters sitting at h=5, v=3.
        n = 0;
        while (!(ah == 5 && av == 3) && n < 400 * CEF) begin
            drive(1'b0, ce_t);
            ce_t = ~ce_t;
            n++;
        end
        check("reach_h5_v3", 32'(ah == 5 && av == 3), 32'd1);
        drive(1'b1, ce_t);

        ce_t = 1'b1;
        for (int i = 0; i < 2 * 176 * CEF + 20; i++) begin
            drive(1'b0, ce_t);
            ce_t = ~ce_t;
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        check("frame_periods_measured", 32'(periods_seen >= 4), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
